frogger_game_ctrl: RTL and testbench

Parametrised game-flow controller for the Frogger top level. It replaces the bare level counter with a registered state machine covering start, play, death, level-up and game over. It also tracks lives, score and the current level, and generates the round-reset and freeze strobes that drive the frog, car and VGA blocks. It consumes the collision module's `death_collision` and `win_collision` and the VGA frame tick. Its outputs feed the seven-segment display, the VGA overlay, and the `reset` inputs of frog and car.

---
 rtl/frogger_game_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_ctrl.sv
// rtl/frogger_game_ctrl.sv - Frogger game-flow FSM: lives, score, level, round-reset and freeze strobes
// Optional round time limit: define FROGGER_ROUND_TIMER_EN.
module frogger_game_ctrl #(
    parameter int LEVEL_W      = 4,
    parameter int MAX_LEVEL    = 8,
    parameter int LIVES        = 3,
    parameter int LIVES_W      = 2,
    parameter int SCORE_W      = 12,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 30,
    parameter int ROUND_FRAMES = 1800
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               death_collision,
    input  logic               win_collision,
    output logic [2:0]         state,
    output logic [LEVEL_W-1:0] current_level,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic               round_reset,
    output logic               freeze,
    output logic               game_over,
    output logic [10:0]        timer_left
);
    localparam int CNT_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef FROGGER_ROUND_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_DYING     = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        timer_q, timer_d;
    logic               round_reset_q, round_reset_d;
    logic               freeze_q, freeze_d;
    logic               game_over_q, game_over_d;
    logic               blank_q;
    logic               start_q, start_vld_q, start_rise_q;
    logic               coll_ok, timeout, death;
    logic [SCORE_W:0]   score_sum;

    // start_vld_q stops a button held through reset from looking like a fresh press
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            level_q       <= '0;
            lives_q       <= '0;
            score_q       <= '0;
            cnt_q         <= '0;
            timer_q       <= '0;
            round_reset_q <= 1'b0;
            freeze_q      <= 1'b1;
            game_over_q   <= 1'b0;
            blank_q       <= 1'b0;
            start_q       <= 1'b0;
            start_vld_q   <= 1'b0;
            start_rise_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            round_reset_q <= round_reset_d;
            freeze_q      <= freeze_d;
            game_over_q   <= game_over_d;
            blank_q       <= round_reset_q;
            start_q       <= start;
            start_vld_q   <= 1'b1;
            start_rise_q  <= start & ~start_q & start_vld_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        lives_d       = lives_q;
        score_d       = score_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        round_reset_d = 1'b0;
        // positions are stale during the reposition cycle and the one after it
        coll_ok       = (state_q == S_PLAY) && !round_reset_q && !blank_q;
        timeout       = TIMER_EN && (state_q == S_PLAY) && frame_tick && (timer_q == 11'd1);
        death         = (coll_ok && death_collision) || timeout;
        score_sum     = {1'b0, score_q} + (SCORE_W+1)'(level_q) + (SCORE_W+1)'(1);

        if (TIMER_EN) begin
            if ((state_q == S_PLAY) && frame_tick && (timer_q != 11'd0)) begin
                timer_d = timer_q - 11'd1;
            end
        end else begin
            timer_d = 11'd0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_rise_q) begin
                    state_d       = S_PLAY;
                    lives_d       = LIVES_W'(LIVES);
                    level_d       = '0;
                    score_d       = '0;
                    round_reset_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (death) begin
                    state_d = S_DYING;
                    cnt_d   = CNT_W'(DEATH_FRAMES);
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end else if (coll_ok && win_collision) begin
                    state_d = S_LEVEL_UP;
                    cnt_d   = CNT_W'(WIN_FRAMES);
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d = '0;
                        if (lives_q == '0) begin
                            state_d = S_GAME_OVER;
                        end else begin
                            state_d       = S_PLAY;
                            round_reset_d = 1'b1;
                        end
                    end
                end
            end
            S_LEVEL_UP: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d         = '0;
                        state_d       = S_PLAY;
                        round_reset_d = 1'b1;
                        if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                            level_d = '0;
                            if (lives_q < LIVES_W'(LIVES)) begin
                                lives_d = lives_q + LIVES_W'(1);
                            end
                        end else begin
                            level_d = level_q + LEVEL_W'(1);
                        end
                    end
                end
            end
            S_GAME_OVER: begin
                if (start_rise_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (TIMER_EN && round_reset_d) begin
            timer_d = 11'(ROUND_FRAMES);
        end
        freeze_d    = (state_d != S_PLAY);
        game_over_d = (state_d == S_GAME_OVER);
    end

    assign state         = state_q;
    assign current_level = level_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign round_reset   = round_reset_q;
    assign freeze        = freeze_q;
    assign game_over     = game_over_q;
    assign timer_left    = timer_q;
endmodule

// File: tb/tb_frogger_game_ctrl.sv
// tb/tb_frogger_game_ctrl.sv - randomized self-checking bench for frogger_game_ctrl against a game-rule model
module tb_frogger_game_ctrl;
    localparam int DF   = 60;
    localparam int WF   = 30;
    localparam int LV   = 3;
    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        death_collision = 1'b0;
    logic        win_collision = 1'b0;
    logic [2:0]  state;
    logic [3:0]  current_level;
    logic [1:0]  lives;
    logic [11:0] score;
    logic        round_reset, freeze, game_over;
    logic [10:0] timer_left;

    int n_vec = 0;
    int n_err = 0;
    int m_lives = 0, m_level = 0, m_score = 0;

    always #5 clk = ~clk;

    frogger_game_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
        .death_collision(death_collision), .win_collision(win_collision),
        .state(state), .current_level(current_level), .lives(lives), .score(score),
        .round_reset(round_reset), .freeze(freeze), .game_over(game_over), .timer_left(timer_left)
    );

    // game rules as plain arithmetic
    function automatic void m_win();
        m_score = (m_score + m_level + 1 > 4095) ? 4095 : m_score + m_level + 1;
    endfunction
    function automatic void m_advance();
        if (m_level == MAXL) begin
            m_level = 0;
            if (m_lives < LV) m_lives++;
        end else begin
            m_level++;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // from the round_reset cycle, step past the two blanked edges
    task automatic settle();
        death_collision = 1'b0;
        win_collision   = 1'b0;
        cyc();
        cyc();
    endtask

    // one frame tick after 0..2 idle cycles; noise drives collisions while frozen
    task automatic tick(input bit noise);
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i <= g; i++) begin
            if (noise) begin
                death_collision = 1'($urandom_range(0, 1));
                win_collision   = 1'($urandom_range(0, 1));
            end
            frame_tick = (i == g);
            cyc();
        end
        frame_tick      = 1'b0;
        death_collision = 1'b0;
        win_collision   = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b0;
        cyc();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        m_lives = LV;
        m_level = 0;
        m_score = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (3) cyc();
        n_vec++;
        if ({state, current_level, lives, score, round_reset, freeze, game_over, timer_left} !==
            {3'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b1, 1'b0, 11'd0}) begin
            n_err++;
            $display("FAIL reset_vals: state=%0d lvl=%0d lives=%0d score=%0d rr=%0b frz=%0b go=%0b tmr=%0d, want 0/0/0/0/0/1/0/0",
                     state, current_level, lives, score, round_reset, freeze, game_over, timer_left);
        end
        reset_n = 1'b1;
        repeat (4) cyc();
        n_vec++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL start_held_across_reset: state=%0d want 0", state);
        end
        start = 1'b0;
        cyc();
    endtask

    task automatic test_start();
        start = 1'b0;
        cyc();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_vec++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL start_latency: state=%0d one edge after press, want 0", state);
        end
        cyc();
        m_lives = LV; m_level = 0; m_score = 0;
        n_vec++;
        if ({state, lives, current_level, score, round_reset, freeze} !== {3'd1, 2'(m_lives), 4'd0, 12'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL start_play: state=%0d lives=%0d lvl=%0d score=%0d rr=%0b frz=%0b, want 1/3/0/0/1/0",
                     state, lives, current_level, score, round_reset, freeze);
        end
        death_collision = 1'b1;
        cyc();
        n_vec++;
        if ({state, lives, round_reset} !== {3'd1, 2'(m_lives), 1'b0}) begin
            n_err++;
            $display("FAIL rr_cycle_death_ignored: state=%0d lives=%0d rr=%0b, want 1/%0d/0", state, lives, round_reset, m_lives);
        end
        cyc();
        death_collision = 1'b0;
        n_vec++;
        if ({state, lives, round_reset} !== {3'd1, 2'(m_lives), 1'b0}) begin
            n_err++;
            $display("FAIL blank_cycle_death_ignored: state=%0d lives=%0d rr=%0b, want 1/%0d/0", state, lives, round_reset, m_lives);
        end
    endtask

    task automatic test_death();
        death_collision = 1'b1;
        cyc();
        m_lives--;
        n_vec++;
        if ({state, lives, freeze} !== {3'd2, 2'(m_lives), 1'b1}) begin
            n_err++;
            $display("FAIL death_enter: state=%0d lives=%0d frz=%0b, want 2/%0d/1", state, lives, freeze, m_lives);
        end
        repeat (4) cyc();
        death_collision = 1'b0;
        n_vec++;
        if ({state, lives} !== {3'd2, 2'(m_lives)}) begin
            n_err++;
            $display("FAIL death_held: state=%0d lives=%0d, want 2/%0d", state, lives, m_lives);
        end
        for (int i = 0; i < DF; i++) begin
            tick(1'b0);
            if (i < DF - 1) begin
                n_vec++;
                if (state !== 3'd2) begin
                    n_err++;
                    $display("FAIL dying_hold: tick %0d state=%0d want 2", i + 1, state);
                end
            end
        end
        n_vec++;
        if ({state, round_reset, lives, freeze} !== {3'd1, 1'b1, 2'(m_lives), 1'b0}) begin
            n_err++;
            $display("FAIL dying_exit: state=%0d rr=%0b lives=%0d frz=%0b, want 1/1/%0d/0", state, round_reset, lives, freeze, m_lives);
        end
    endtask

    task automatic test_blanking();
        win_collision = 1'b1;
        cyc();
        n_vec++;
        if ({state, score} !== {3'd1, 12'(m_score)}) begin
            n_err++;
            $display("FAIL blank_win_rr: state=%0d score=%0d, want 1/%0d", state, score, m_score);
        end
        cyc();
        n_vec++;
        if ({state, score} !== {3'd1, 12'(m_score)}) begin
            n_err++;
            $display("FAIL blank_win_next: state=%0d score=%0d, want 1/%0d", state, score, m_score);
        end
        cyc();
        win_collision = 1'b0;
        m_win();
        n_vec++;
        if ({state, score} !== {3'd3, 12'(m_score)}) begin
            n_err++;
            $display("FAIL win_after_blank: state=%0d score=%0d, want 3/%0d", state, score, m_score);
        end
        for (int i = 0; i < WF; i++) tick(1'b1);
        m_advance();
        n_vec++;
        if ({state, round_reset, current_level} !== {3'd1, 1'b1, 4'(m_level)}) begin
            n_err++;
            $display("FAIL levelup_exit: state=%0d rr=%0b lvl=%0d, want 1/1/%0d", state, round_reset, current_level, m_level);
        end
    endtask

    task automatic test_game_over();
        settle();
        while (m_lives > 0) begin
            death_collision = 1'b1;
            cyc();
            death_collision = 1'b0;
            m_lives--;
            for (int i = 0; i < DF; i++) tick(1'b1);
            if (m_lives > 0) settle();
        end
        n_vec++;
        if ({state, game_over, freeze, lives, current_level, score} !==
            {3'd4, 1'b1, 1'b1, 2'd0, 4'(m_level), 12'(m_score)}) begin
            n_err++;
            $display("FAIL game_over: state=%0d go=%0b frz=%0b lives=%0d lvl=%0d score=%0d, want 4/1/1/0/%0d/%0d",
                     state, game_over, freeze, lives, current_level, score, m_level, m_score);
        end
        repeat (20) begin
            death_collision = 1'($urandom_range(0, 1));
            win_collision   = 1'($urandom_range(0, 1));
            frame_tick      = 1'($urandom_range(0, 1));
            cyc();
        end
        death_collision = 1'b0; win_collision = 1'b0; frame_tick = 1'b0;
        n_vec++;
        if ({state, current_level, score} !== {3'd4, 4'(m_level), 12'(m_score)}) begin
            n_err++;
            $display("FAIL game_over_hold: state=%0d lvl=%0d score=%0d, want 4/%0d/%0d", state, current_level, score, m_level, m_score);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        n_vec++;
        if ({state, game_over, freeze} !== {3'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL go_to_idle: state=%0d go=%0b frz=%0b, want 0/0/1", state, game_over, freeze);
        end
        start_game();
        n_vec++;
        if ({state, lives, current_level, score, round_reset} !== {3'd1, 2'd3, 4'd0, 12'd0, 1'b1}) begin
            n_err++;
            $display("FAIL new_game: state=%0d lives=%0d lvl=%0d score=%0d rr=%0b, want 1/3/0/0/1",
                     state, lives, current_level, score, round_reset);
        end
    endtask

    task automatic test_wins();
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                settle();
                death_collision = 1'b1;
                cyc();
                death_collision = 1'b0;
                m_lives--;
                for (int i = 0; i < DF; i++) tick(1'b1);
                n_vec++;
                if (lives !== 2'd2) begin
                    n_err++;
                    $display("FAIL pre_wrap_lives: lives=%0d want 2", lives);
                end
            end
            for (int w = 0; w < 9; w++) begin
                settle();
                win_collision = 1'b1;
                cyc();
                win_collision = 1'b0;
                m_win();
                n_vec++;
                if ({state, score} !== {3'd3, 12'(m_score)}) begin
                    n_err++;
                    $display("FAIL win_enter p%0d w%0d: state=%0d score=%0d, want 3/%0d", p, w, state, score, m_score);
                end
                for (int i = 0; i < WF; i++) tick(1'b1);
                m_advance();
                n_vec++;
                if ({state, round_reset, lives, current_level, score} !==
                    {3'd1, 1'b1, 2'(m_lives), 4'(m_level), 12'(m_score)}) begin
                    n_err++;
                    $display("FAIL win_exit p%0d w%0d: state=%0d rr=%0b lives=%0d lvl=%0d score=%0d, want 1/1/%0d/%0d/%0d",
                             p, w, state, round_reset, lives, current_level, score, m_lives, m_level, m_score);
                end
            end
            n_vec++;
            if ({score, current_level, lives} !== {12'(45 * (p + 1)), 4'd0, 2'd3}) begin
                n_err++;
                $display("FAIL nine_wins p%0d: score=%0d lvl=%0d lives=%0d, want %0d/0/3", p, score, current_level, lives, 45 * (p + 1));
            end
        end
    endtask

    task automatic test_simultaneous();
        settle();
        death_collision = 1'b1;
        win_collision   = 1'b1;
        cyc();
        death_collision = 1'b0;
        win_collision   = 1'b0;
        m_lives--;
        n_vec++;
        if ({state, score, lives} !== {3'd2, 12'(m_score), 2'(m_lives)}) begin
            n_err++;
            $display("FAIL death_beats_win: state=%0d score=%0d lives=%0d, want 2/%0d/%0d", state, score, lives, m_score, m_lives);
        end
        for (int i = 0; i < DF; i++) tick(1'b1);
        n_vec++;
        if ({state, round_reset} !== {3'd1, 1'b1}) begin
            n_err++;
            $display("FAIL simul_exit: state=%0d rr=%0b, want 1/1", state, round_reset);
        end
    endtask

    task automatic test_random();
        int kind, hold, es;
        for (int ev = 0; ev < 16; ev++) begin
            settle();
            repeat ($urandom_range(0, 5)) begin
                frame_tick = 1'($urandom_range(0, 1));
                cyc();
            end
            frame_tick = 1'b0;
            kind = $urandom_range(0, 2);
            hold = $urandom_range(1, 4);
            death_collision = (kind != 1);
            win_collision   = (kind != 0);
            repeat (hold) cyc();
            death_collision = 1'b0;
            win_collision   = 1'b0;
            if (kind != 1) m_lives--;
            else m_win();
            es = (kind != 1) ? 2 : 3;
            n_vec++;
            if ({state, lives, current_level, score, timer_left} !==
                {3'(es), 2'(m_lives), 4'(m_level), 12'(m_score), 11'd0}) begin
                n_err++;
                $display("FAIL rand_event %0d kind %0d: state=%0d lives=%0d lvl=%0d score=%0d tmr=%0d, want %0d/%0d/%0d/%0d/0",
                         ev, kind, state, lives, current_level, score, timer_left, es, m_lives, m_level, m_score);
            end
            for (int i = 0; i < ((kind != 1) ? DF : WF); i++) tick(1'b1);
            if (kind == 1) m_advance();
            es = (kind != 1 && m_lives == 0) ? 4 : 1;
            n_vec++;
            if ({state, lives, current_level, score, round_reset} !==
                {3'(es), 2'(m_lives), 4'(m_level), 12'(m_score), (es == 1)}) begin
                n_err++;
                $display("FAIL rand_exit %0d: state=%0d lives=%0d lvl=%0d score=%0d rr=%0b, want %0d/%0d/%0d/%0d/%0b",
                         ev, state, lives, current_level, score, round_reset, es, m_lives, m_level, m_score, es == 1);
            end
            if (es == 4) begin
                start = 1'b1;
                cyc();
                start = 1'b0;
                cyc();
                start_game();
            end
        end
    endtask

    task automatic test_reset_mid();
        settle();
        death_collision = 1'b1;
        cyc();
        death_collision = 1'b0;
        tick(1'b0);
        tick(1'b0);
        reset_n = 1'b0;
        cyc();
        n_vec++;
        if ({state, current_level, lives, score, round_reset, freeze, game_over} !==
            {3'd0, 4'd0, 2'd0, 12'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: state=%0d lvl=%0d lives=%0d score=%0d rr=%0b frz=%0b go=%0b, want 0/0/0/0/0/1/0",
                     state, current_level, lives, score, round_reset, freeze, game_over);
        end
        reset_n = 1'b1;
        repeat (3) cyc();
        n_vec++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid_idle: state=%0d want 0", state);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_death();
        test_blanking();
        test_game_over();
        test_wins();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
